// File: rtl/cache_refill_ctrl.sv
// Refill sequencer for a direct-mapped data cache: one CPU load at a time,
// single-cycle tag lookup, 4-beat line fetch from memory on a miss, one-cycle
// line write into the array, and saturating hit/miss counters.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  output logic                cpu_ready,
  output logic                cpu_done,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic [ADDR_W-1:0]   lk_addr,
  input  logic                lk_hit,
  input  logic [4*DATA_W-1:0] lk_line,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fill_we,
  output logic [4*DATA_W-1:0] fill_line,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StFetch,
    StFill,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e                   state_q;
  logic [ADDR_W-1:0]        lk_addr_q;
  logic [DATA_W-1:0]        cpu_rdata_q;
  logic [1:0]               beat_q;
  logic [3:0][DATA_W-1:0]   buf_q;
  logic [CNT_W-1:0]         hit_cnt_q;
  logic [CNT_W-1:0]         miss_cnt_q;
  logic [3:0][DATA_W-1:0]   lk_words;

  // Word view of the array line, w0 in the least significant slot.
  assign lk_words = lk_line;

  // Sequencer and datapath registers; reset discards any partial line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      lk_addr_q   <= '0;
      cpu_rdata_q <= '0;
      beat_q      <= 2'd0;
      buf_q       <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_req) begin
            lk_addr_q <= cpu_addr;
            state_q   <= StLookup;
          end
        end
        StLookup: begin
          if (lk_hit) begin
            cpu_rdata_q <= lk_words[lk_addr_q[1:0]];
            if (hit_cnt_q != CntMax) begin
              hit_cnt_q <= hit_cnt_q + CntOne;
            end
            state_q <= StDone;
          end else begin
            if (miss_cnt_q != CntMax) begin
              miss_cnt_q <= miss_cnt_q + CntOne;
            end
            beat_q  <= 2'd0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          // Address stays put until memory accepts the beat.
          if (mem_ack) begin
            buf_q[beat_q] <= mem_rdata;
            if (beat_q == 2'd3) begin
              state_q <= StFill;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        StFill: begin
          cpu_rdata_q <= buf_q[lk_addr_q[1:0]];
          state_q     <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Strobes decode straight from state so reset drops them asynchronously.
  assign cpu_ready = (state_q == StIdle);
  assign cpu_done  = (state_q == StDone);
  assign mem_req   = (state_q == StFetch);
  assign fill_we   = (state_q == StFill);

  assign cpu_rdata = cpu_rdata_q;
  assign lk_addr   = lk_addr_q;
  assign mem_addr  = {lk_addr_q[ADDR_W-1:2], beat_q};
  assign fill_line = buf_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus predicts each load's data,
// hit/miss outcome, latency and counters from a tag-tracking model; a negedge
// monitor pops and compares whenever the DUT signals completion.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [14:0]  cpu_addr;
  logic         cpu_ready;
  logic         cpu_done;
  logic [31:0]  cpu_rdata;
  logic [14:0]  lk_addr;
  logic         lk_hit;
  logic [127:0] lk_line;
  logic         mem_req;
  logic [14:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         fill_we;
  logic [127:0] fill_line;
  logic [14:0]  hit_cnt;
  logic [14:0]  miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl #(
    .ADDR_W(15),
    .DATA_W(32),
    .CNT_W (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_ready(cpu_ready),
    .cpu_done (cpu_done),
    .cpu_rdata(cpu_rdata),
    .lk_addr  (lk_addr),
    .lk_hit   (lk_hit),
    .lk_line  (lk_line),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .fill_we  (fill_we),
    .fill_line(fill_line),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  // Backing memory contents; words 4..7 are 10,12,14,16.
  function automatic logic [31:0] mem_fn(input logic [14:0] a);
    if (a >= 15'd4 && a <= 15'd7) return 32'(a) * 32'd2 + 32'd2;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Cache array environment: written only by the DUT fill strobe.
  bit           arr_valid [1024];
  logic [2:0]   arr_tag   [1024];
  logic [127:0] arr_line  [1024];

  assign lk_hit  = arr_valid[lk_addr[11:2]] && (arr_tag[lk_addr[11:2]] == lk_addr[14:12]);
  assign lk_line = arr_line[lk_addr[11:2]];

  always @(posedge clk) begin
    if (fill_we) begin
      arr_valid[lk_addr[11:2]] <= 1'b1;
      arr_tag[lk_addr[11:2]]   <= lk_addr[14:12];
      arr_line[lk_addr[11:2]]  <= fill_line;
    end
  end

  // Memory responder: acks each beat after 'stall' wait cycles; random
  // acks while no request is pending must be ignored by the DUT.
  int   stall = 0;
  int   wait_cnt = 0;
  logic noise = 1'b0;

  assign mem_ack   = mem_req ? (wait_cnt == stall) : noise;
  assign mem_rdata = mem_fn(mem_addr);

  always @(posedge clk) begin
    noise <= 1'($urandom_range(0, 1));
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Reference model: which tag each index holds, plus expected counters.
  typedef struct {
    logic [14:0] addr;
    logic [31:0] data;
    logic        hit;
    int          lat;
    int          hits;
    int          misses;
  } exp_t;

  exp_t       q[$];
  bit         pred_valid [1024];
  logic [2:0] pred_tag   [1024];
  int         exp_hits = 0;
  int         exp_misses = 0;

  task automatic push(input logic [14:0] a);
    exp_t e;
    int   idx;
    idx    = int'(a[11:2]);
    e.addr = a;
    e.data = mem_fn(a);
    e.hit  = pred_valid[idx] && (pred_tag[idx] == a[14:12]);
    if (e.hit) begin
      if (exp_hits < 32767) exp_hits++;
      e.lat = 2;
    end else begin
      if (exp_misses < 32767) exp_misses++;
      pred_valid[idx] = 1'b1;
      pred_tag[idx]   = a[14:12];
      e.lat = 2 + 4 * (stall + 1) + 1;
    end
    e.hits   = exp_hits;
    e.misses = exp_misses;
    q.push_back(e);
  endtask

  // Monitor: per-cycle protocol checks and scoreboard pop on cpu_done.
  int          cyc = 0;
  int          acc_cyc = 0;
  int          beats = 0;
  int          fills = 0;
  bit          busy = 1'b0;
  logic [31:0] last_data = '0;
  exp_t        mon_e;
  logic [14:0] base;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      busy      = 1'b0;
      beats     = 0;
      fills     = 0;
      last_data = '0;
    end else begin
      check("cpu_ready", cpu_ready, !busy);
      if (!busy) begin
        check("idle_mem_req", mem_req, 1'b0);
        check("idle_fill_we", fill_we, 1'b0);
      end
      if (q.size() == 0) check("spurious_done", cpu_done, 1'b0);
      if (busy && q.size() > 0 && q[0].hit) check("mem_req_on_hit", mem_req, 1'b0);
      if (mem_req && q.size() > 0) begin
        check("mem_addr", mem_addr, {q[0].addr[14:2], 2'(beats)});
        if (mem_ack) beats++;
      end
      if (fill_we && q.size() > 0) begin
        fills++;
        base = {q[0].addr[14:2], 2'b00};
        check("fill_line", fill_line, {mem_fn(base + 15'd3), mem_fn(base + 15'd2),
                                       mem_fn(base + 15'd1), mem_fn(base)});
      end
      if (cpu_done && q.size() > 0) begin
        mon_e = q.pop_front();
        check("cpu_rdata", cpu_rdata, mon_e.data);
        check("latency", cyc - acc_cyc, mon_e.lat);
        check("hit_cnt", hit_cnt, mon_e.hits);
        check("miss_cnt", miss_cnt, mon_e.misses);
        check("fill_count", fills, mon_e.hit ? 0 : 1);
        last_data = mon_e.data;
        busy = 1'b0;
      end
      if (cpu_ready && cpu_req) begin
        check("rdata_hold", cpu_rdata, last_data);
        acc_cyc = cyc;
        busy    = 1'b1;
        beats   = 0;
        fills   = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(posedge clk); #1;
    while (!cpu_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cpu_ready) check("ready_timeout", cpu_ready, 1'b1);
  endtask

  task automatic issue(input logic [14:0] a, input int st, input int gap);
    repeat (gap) @(posedge clk);
    wait_ready();
    stall    = st;
    cpu_req  = 1'b1;
    cpu_addr = a;
    push(a);
    @(posedge clk); #1;
    cpu_req  = 1'b0;
    cpu_addr = 15'($urandom);
  endtask

  // Request held high across a whole miss: the second load is taken only in
  // the IDLE cycle after DONE.
  task automatic issue_hold(input logic [14:0] a, input logic [14:0] b);
    wait_ready();
    stall    = 0;
    cpu_req  = 1'b1;
    cpu_addr = a;
    push(a);
    @(posedge clk); #1;
    cpu_addr = b;
    push(b);
    wait_ready();
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic reset_mid_fetch(input logic [14:0] a);
    bit         pv;
    logic [2:0] pt;
    int         idx;
    idx = int'(a[11:2]);
    pv  = pred_valid[idx];
    pt  = pred_tag[idx];
    issue(a, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("fetch_before_rst", mem_req, 1'b1);
    check("beat_before_rst", mem_addr, {a[14:2], 2'd2});
    rst = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_fill_we", fill_we, 1'b0);
    check("rst_ready", cpu_ready, 1'b1);
    check("rst_done", cpu_done, 1'b0);
    check("rst_hit_cnt", hit_cnt, 15'd0);
    check("rst_miss_cnt", miss_cnt, 15'd0);
    q.delete();
    exp_hits        = 0;
    exp_misses      = 0;
    pred_valid[idx] = pv;
    pred_tag[idx]   = pt;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_ready", cpu_ready, 1'b1);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_fill_we", fill_we, 1'b0);
    check("reset_done", cpu_done, 1'b0);
    check("reset_hit_cnt", hit_cnt, 15'd0);
    check("reset_miss_cnt", miss_cnt, 15'd0);
    check("reset_rdata", cpu_rdata, 32'd0);
    check("reset_mem_addr", mem_addr, 15'd0);
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", cpu_ready, 1'b1);
    check("post_reset_mem_req", mem_req, 1'b0);

    // Cold miss, hit on the filled line, conflict miss with stalled memory.
    issue(15'h0005, 0, 0);
    issue(15'h0007, 0, 1);
    issue(15'h1005, 3, 1);

    // Reset while fetching beat 2, then the same line must miss again.
    reset_mid_fetch(15'h2A49);
    issue(15'h2A49, 0, 1);

    issue_hold(15'h0FFD, 15'h0FFE);

    // Random loads over a few indices and tags to mix hits and conflicts.
    for (int i = 0; i < 150; i++) begin
      issue({3'($urandom_range(0, 3)), 10'($urandom_range(0, 7)), 2'($urandom_range(0, 3))},
            $urandom_range(0, 2), $urandom_range(0, 2));
    end

    n = 0;
    while ((q.size() != 0 || !cpu_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) check("drain", q.size(), 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
